// File: rtl/burst_pkg.sv
// Shared types for the burst arbiter: FSM state encoding and command-type constants.
package burst_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_CMD  = 3'd1,
    ST_RD_DATA = 3'd2,
    ST_WR_CMD  = 3'd3,
    ST_WR_DATA = 3'd4
  } state_e;

  localparam logic CMD_RD = 1'b0;
  localparam logic CMD_WR = 1'b1;

  function automatic logic is_cmd_state(input state_e s);
    return (s == ST_RD_CMD) || (s == ST_WR_CMD);
  endfunction

endpackage

// File: rtl/burst_addr_ctr.sv
// Frame offset counter: advances by STEP on each accepted command, wraps to 0 at LIMIT,
// and clears to 0 on request (clear wins over advance).
module burst_addr_ctr #(
  parameter int STEP  = 16,
  parameter int LIMIT = 2073600,
  parameter int W     = 21
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         adv_i,
  output logic [W-1:0] off_o
);

  localparam int WP1 = W + 1;

  logic [W-1:0] off_q, off_d;
  logic [W:0]   sum_s;

  // Next offset: clear, advance-with-wrap, or hold.
  always_comb begin
    sum_s = {1'b0, off_q} + WP1'(STEP);
    off_d = off_q;
    if (clr_i) begin
      off_d = '0;
    end else if (adv_i) begin
      if (sum_s >= WP1'(LIMIT)) begin
        off_d = '0;
      end else begin
        off_d = sum_s[W-1:0];
      end
    end else begin
      off_d = off_q;
    end
  end

  // Offset register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      off_q <= '0;
    end else begin
      off_q <= off_d;
    end
  end

  assign off_o = off_q;

endmodule

// File: rtl/burst_arb.sv
// Read/write burst arbiter between a display read FIFO and a capture write FIFO.
// Optional macro BURST_ARB_RD_PRIO_EN: strict read priority instead of round-robin.
module burst_arb
  import burst_pkg::*;
#(
  parameter int BURST_LEN   = 16,
  parameter int AW          = 28,
  parameter int FRAME_WORDS = 2073600,
  parameter int RD_BASE     = 0,
  parameter int WR_BASE     = 2097152
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          rd_req_i,
  input  logic          wr_req_i,
  input  logic          vsync_i,
  output logic          cmd_val_o,
  input  logic          cmd_rdy_i,
  output logic          cmd_wr_o,
  output logic [AW-1:0] cmd_addr_o,
  input  logic          rd_beat_i,
  input  logic          wr_beat_i,
  output logic          rfifo_incr_o,
  output logic          wfifo_incr_o,
  output logic          busy_o
);

  localparam int OW  = $clog2(FRAME_WORDS + 1);
  localparam int BCW = $clog2(BURST_LEN);
  localparam logic [BCW-1:0] LAST_BEAT = BCW'(BURST_LEN - 1);

  state_e          state_q, state_d;
  logic [BCW-1:0]  beat_cnt_q, beat_cnt_d;
  logic            vs_pend_q, vs_pend_d;
  logic            cmd_val_q, cmd_val_d;
  logic            cmd_wr_q, cmd_wr_d;
  logic [AW-1:0]   cmd_addr_q, cmd_addr_d;
  logic            busy_q, busy_d;

  logic            clr_s, rd_adv_s, wr_adv_s, beat_s, last_s, rd_first_s;
  logic [OW-1:0]   rd_off_s, wr_off_s;
  logic [AW-1:0]   rd_addr_s, wr_addr_s;

  assign clr_s    = (state_q == ST_IDLE) && vs_pend_q;
  assign rd_adv_s = (state_q == ST_RD_CMD) && cmd_rdy_i;
  assign wr_adv_s = (state_q == ST_WR_CMD) && cmd_rdy_i;
  assign beat_s   = ((state_q == ST_RD_DATA) && rd_beat_i) ||
                    ((state_q == ST_WR_DATA) && wr_beat_i);
  assign last_s   = beat_s && (beat_cnt_q == LAST_BEAT);

  // A command issued in the same IDLE cycle as a vsync clear starts at offset 0.
  assign rd_addr_s = clr_s ? AW'(RD_BASE) : AW'(RD_BASE) + AW'(rd_off_s);
  assign wr_addr_s = clr_s ? AW'(WR_BASE) : AW'(WR_BASE) + AW'(wr_off_s);

  burst_addr_ctr #(.STEP(BURST_LEN), .LIMIT(FRAME_WORDS), .W(OW)) u_rd_ctr (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (clr_s),
    .adv_i (rd_adv_s),
    .off_o (rd_off_s)
  );

  burst_addr_ctr #(.STEP(BURST_LEN), .LIMIT(FRAME_WORDS), .W(OW)) u_wr_ctr (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (clr_s),
    .adv_i (wr_adv_s),
    .off_o (wr_off_s)
  );

`ifdef BURST_ARB_RD_PRIO_EN
  assign rd_first_s = 1'b1;
`else
  logic rr_rd_first_q, rr_rd_first_d;

  // Round-robin: after a completed burst the other type gets the next tie.
  always_comb begin
    rr_rd_first_d = rr_rd_first_q;
    if (last_s) begin
      rr_rd_first_d = (state_q == ST_WR_DATA);
    end else begin
      rr_rd_first_d = rr_rd_first_q;
    end
  end

  // Round-robin register, read-first out of reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_rd_first_q <= 1'b1;
    end else begin
      rr_rd_first_q <= rr_rd_first_d;
    end
  end

  assign rd_first_s = rr_rd_first_q;
`endif

  // FSM next state, beat counter, command latch and vsync pending flag.
  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    cmd_wr_d   = cmd_wr_q;
    cmd_addr_d = cmd_addr_q;
    vs_pend_d  = clr_s ? vsync_i : (vs_pend_q | vsync_i);
    case (state_q)
      ST_IDLE: begin
        if (rd_req_i && (!wr_req_i || rd_first_s)) begin
          state_d    = ST_RD_CMD;
          cmd_wr_d   = CMD_RD;
          cmd_addr_d = rd_addr_s;
        end else if (wr_req_i) begin
          state_d    = ST_WR_CMD;
          cmd_wr_d   = CMD_WR;
          cmd_addr_d = wr_addr_s;
        end else begin
          state_d    = ST_IDLE;
        end
      end
      ST_RD_CMD: begin
        if (cmd_rdy_i) begin
          state_d = ST_RD_DATA;
        end else begin
          state_d = ST_RD_CMD;
        end
      end
      ST_WR_CMD: begin
        if (cmd_rdy_i) begin
          state_d = ST_WR_DATA;
        end else begin
          state_d = ST_WR_CMD;
        end
      end
      ST_RD_DATA, ST_WR_DATA: begin
        if (last_s) begin
          state_d    = ST_IDLE;
          beat_cnt_d = '0;
        end else if (beat_s) begin
          beat_cnt_d = beat_cnt_q + BCW'(1);
        end else begin
          beat_cnt_d = beat_cnt_q;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        beat_cnt_d = '0;
      end
    endcase
    cmd_val_d = is_cmd_state(state_d);
    busy_d    = (state_d != ST_IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      beat_cnt_q <= '0;
      vs_pend_q  <= 1'b0;
      cmd_val_q  <= 1'b0;
      cmd_wr_q   <= CMD_RD;
      cmd_addr_q <= AW'(RD_BASE);
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      vs_pend_q  <= vs_pend_d;
      cmd_val_q  <= cmd_val_d;
      cmd_wr_q   <= cmd_wr_d;
      cmd_addr_q <= cmd_addr_d;
      busy_q     <= busy_d;
    end
  end

  assign cmd_val_o    = cmd_val_q;
  assign cmd_wr_o     = cmd_wr_q;
  assign cmd_addr_o   = cmd_addr_q;
  assign busy_o       = busy_q;
  // FIFO strobes follow the beat inputs directly, forced low while reset is held.
  assign rfifo_incr_o = !rst_i && (state_q == ST_RD_DATA) && rd_beat_i;
  assign wfifo_incr_o = !rst_i && (state_q == ST_WR_DATA) && wr_beat_i;

endmodule
